// File: rtl/pass_feeder_pkg.sv
// Shared definitions for the Smith-Waterman pass feeder.
//   VEF_BIT   : signed V/E/F score width, identical to the PE score width.
//   T_MAX_LEN : deepest target supported; sets the boundary buffer depth.
//   ADDR_BIT  : log2(T_MAX_LEN).
//   BUF_W     : width of one boundary entry {v, v_alpha, f}.
//   state_e   : feeder FSM encoding.
package pass_feeder_pkg;

   localparam int unsigned VEF_BIT   = 16;
   localparam int unsigned T_MAX_LEN = 1024;
   localparam int unsigned ADDR_BIT  = 10;
   localparam int unsigned BUF_W     = 3 * VEF_BIT;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

endpackage

// File: rtl/pass_feeder_boundary_buf.sv
// Boundary column buffer for the pass feeder.
// Register array with asynchronous read and synchronous write; not reset.
//   clk     : clock.
//   we_i    : write enable.
//   waddr_i : write index.
//   wdata_i : write data {v, v_alpha, f}.
//   raddr_i : read index.
//   rdata_o : read data, combinational from raddr_i.
module pass_feeder_boundary_buf #(
   parameter int unsigned Width   = 48,
   parameter int unsigned Depth   = 1024,
   parameter int unsigned AddrBit = 10
) (
   input  logic               clk,
   input  logic               we_i,
   input  logic [AddrBit-1:0] waddr_i,
   input  logic [Width-1:0]   wdata_i,
   input  logic [AddrBit-1:0] raddr_i,
   output logic [Width-1:0]   rdata_o
);

   logic [Width-1:0] mem_q [Depth];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pass_feeder.sv
// Upstream boundary stage of the systolic Smith-Waterman PE array.
// Streams target characters into the first PE, drives enable/lock/newLine, supplies the
// left-boundary column (zeros/minusAlpha on a first pass, replayed buffer otherwise) and
// captures the last PE's column for the next pass.
//   clk, rst              : clock, asynchronous active-low reset.
//   start, first_pass     : pass request and boundary source, sampled in idle.
//   t_len                 : target length for the pass, sampled with start.
//   minusAlpha            : gap-open penalty used as first-pass boundary.
//   t_valid/t_data/t_ready: target character handshake.
//   pe_enable, pe_lock    : array enable (low clears) and lock (high freezes).
//   newLine, tOut, vOut, vOut_alpha, fOut : registered feed into the first PE.
//   cap_valid, cap_v, cap_v_alpha, cap_f  : last PE outputs to capture.
//   done                  : one-cycle pulse once the pass is fully captured.
module pass_feeder
   import pass_feeder_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               first_pass,
   input  logic [ADDR_BIT:0]  t_len,
   input  logic [VEF_BIT-1:0] minusAlpha,
   input  logic               t_valid,
   input  logic [1:0]         t_data,
   output logic               t_ready,
   output logic               pe_enable,
   output logic               pe_lock,
   output logic               newLine,
   output logic [1:0]         tOut,
   output logic [VEF_BIT-1:0] vOut,
   output logic [VEF_BIT-1:0] vOut_alpha,
   output logic [VEF_BIT-1:0] fOut,
   input  logic               cap_valid,
   input  logic [VEF_BIT-1:0] cap_v,
   input  logic [VEF_BIT-1:0] cap_v_alpha,
   input  logic [VEF_BIT-1:0] cap_f,
   output logic               done
);

   localparam logic [ADDR_BIT:0] CntOne = 1;

   state_e              state_q, state_d;
   logic [ADDR_BIT:0]   send_cnt_q, send_cnt_d;
   logic [ADDR_BIT:0]   cap_cnt_q, cap_cnt_d;
   logic [ADDR_BIT:0]   t_len_q, t_len_d;
   logic                first_pass_q, first_pass_d;
   logic [1:0]          t_out_q, t_out_d;
   logic                new_line_q, new_line_d;
   logic [VEF_BIT-1:0]  v_out_q, v_out_d;
   logic [VEF_BIT-1:0]  v_alpha_q, v_alpha_d;
   logic [VEF_BIT-1:0]  f_out_q, f_out_d;
   logic                pe_lock_q, pe_lock_d;

   logic                fire;
   logic                cap_en;
   logic [BUF_W-1:0]    rd_data;
   logic [BUF_W-1:0]    wr_data;

   assign fire    = (state_q == StRun) & t_valid;
   // Captures only count while the array advances and the pass still needs cells.
   assign cap_en  = cap_valid & ~pe_lock_q & ((state_q == StRun) | (state_q == StDrain)) &
                    (cap_cnt_q != t_len_q);
   assign wr_data = {cap_v, cap_v_alpha, cap_f};

   // The write of index i trails its read by the array latency, so one buffer serves both.
   pass_feeder_boundary_buf #(
      .Width   (BUF_W),
      .Depth   (T_MAX_LEN),
      .AddrBit (ADDR_BIT)
   ) u_boundary_buf (
      .clk     (clk),
      .we_i    (cap_en),
      .waddr_i (cap_cnt_q[ADDR_BIT-1:0]),
      .wdata_i (wr_data),
      .raddr_i (send_cnt_q[ADDR_BIT-1:0]),
      .rdata_o (rd_data)
   );

   always_comb begin
      state_d      = state_q;
      send_cnt_d   = send_cnt_q;
      cap_cnt_d    = cap_cnt_q;
      t_len_d      = t_len_q;
      first_pass_d = first_pass_q;
      t_out_d      = t_out_q;
      new_line_d   = new_line_q;
      v_out_d      = v_out_q;
      v_alpha_d    = v_alpha_q;
      f_out_d      = f_out_q;
      pe_lock_d    = 1'b0;

      if (cap_en) begin
         cap_cnt_d = cap_cnt_q + CntOne;
      end

      unique case (state_q)
         StIdle: begin
            t_out_d    = '0;
            new_line_d = 1'b0;
            v_out_d    = '0;
            v_alpha_d  = '0;
            f_out_d    = '0;
            if (start) begin
               t_len_d      = t_len;
               first_pass_d = first_pass;
               send_cnt_d   = '0;
               cap_cnt_d    = '0;
               if (t_len == '0) begin
                  state_d = StDone;
               end else begin
                  state_d   = StRun;
                  // Hold the array until the first character is registered.
                  pe_lock_d = 1'b1;
               end
            end
         end
         StRun: begin
            pe_lock_d = ~fire;
            if (fire) begin
               t_out_d    = t_data;
               new_line_d = (send_cnt_q == '0);
               if (first_pass_q) begin
                  v_out_d   = '0;
                  v_alpha_d = minusAlpha;
                  f_out_d   = minusAlpha;
               end else begin
                  v_out_d   = rd_data[3*VEF_BIT-1 -: VEF_BIT];
                  v_alpha_d = rd_data[2*VEF_BIT-1 -: VEF_BIT];
                  f_out_d   = rd_data[VEF_BIT-1:0];
               end
               send_cnt_d = send_cnt_q + CntOne;
               if (send_cnt_q == (t_len_q - CntOne)) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            // Padding cells pushed behind the last character.
            t_out_d    = '0;
            new_line_d = 1'b0;
            v_out_d    = '0;
            v_alpha_d  = '0;
            f_out_d    = '0;
            if (cap_cnt_d == t_len_q) begin
               state_d = StDone;
            end
         end
         StDone: begin
            t_out_d    = '0;
            new_line_d = 1'b0;
            v_out_d    = '0;
            v_alpha_d  = '0;
            f_out_d    = '0;
            state_d    = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         send_cnt_q   <= '0;
         cap_cnt_q    <= '0;
         t_len_q      <= '0;
         first_pass_q <= 1'b0;
         t_out_q      <= '0;
         new_line_q   <= 1'b0;
         v_out_q      <= '0;
         v_alpha_q    <= '0;
         f_out_q      <= '0;
         pe_lock_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         send_cnt_q   <= send_cnt_d;
         cap_cnt_q    <= cap_cnt_d;
         t_len_q      <= t_len_d;
         first_pass_q <= first_pass_d;
         t_out_q      <= t_out_d;
         new_line_q   <= new_line_d;
         v_out_q      <= v_out_d;
         v_alpha_q    <= v_alpha_d;
         f_out_q      <= f_out_d;
         pe_lock_q    <= pe_lock_d;
      end
   end

   assign t_ready    = (state_q == StRun);
   assign pe_enable  = (state_q != StIdle);
   assign pe_lock    = pe_lock_q;
   assign newLine    = new_line_q;
   assign tOut       = t_out_q;
   assign vOut       = v_out_q;
   assign vOut_alpha = v_alpha_q;
   assign fOut       = f_out_q;
   assign done       = (state_q == StDone);

endmodule

// File: tb/tb_pass_feeder.sv
module tb_pass_feeder;

   localparam logic [15:0] MA = 16'hFFFE;  // minusAlpha = -2

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        first_pass;
   logic [10:0] t_len;
   logic [15:0] minusAlpha;
   logic        t_valid;
   logic [1:0]  t_data;
   logic        t_ready;
   logic        pe_enable;
   logic        pe_lock;
   logic        newLine;
   logic [1:0]  tOut;
   logic [15:0] vOut;
   logic [15:0] vOut_alpha;
   logic [15:0] fOut;
   logic        cap_valid;
   logic [15:0] cap_v;
   logic [15:0] cap_v_alpha;
   logic [15:0] cap_f;
   logic        done;

   pass_feeder dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .first_pass (first_pass),
      .t_len      (t_len),
      .minusAlpha (minusAlpha),
      .t_valid    (t_valid),
      .t_data     (t_data),
      .t_ready    (t_ready),
      .pe_enable  (pe_enable),
      .pe_lock    (pe_lock),
      .newLine    (newLine),
      .tOut       (tOut),
      .vOut       (vOut),
      .vOut_alpha (vOut_alpha),
      .fOut       (fOut),
      .cap_valid  (cap_valid),
      .cap_v      (cap_v),
      .cap_v_alpha(cap_v_alpha),
      .cap_f      (cap_f),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  t;
      logic        nl;
      logic [15:0] v;
      logic [15:0] va;
      logic [15:0] f;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] mv  [8];
   logic [15:0] mva [8];
   logic [15:0] mf  [8];
   int          mcap;
   int          total = 0;
   int          bad   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one character and queue what the feeder must present after the edge.
   task automatic send(input logic [1:0] d, input logic nl, input logic [15:0] v,
                       input logic [15:0] va, input logic [15:0] f);
      exp_t e;
      e.t  = d;
      e.nl = nl;
      e.v  = v;
      e.va = va;
      e.f  = f;
      sb_q.push_back(e);
      t_valid = 1'b1;
      t_data  = d;
   endtask

   task automatic check_fire(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s: observed=empty-scoreboard expected=entry", tag);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_t"},    tOut,       e.t);
         check({tag, "_nl"},   newLine,    e.nl);
         check({tag, "_v"},    vOut,       e.v);
         check({tag, "_va"},   vOut_alpha, e.va);
         check({tag, "_f"},    fOut,       e.f);
         check({tag, "_lock"}, pe_lock,    1'b0);
      end
   endtask

   // Present a capture that must be accepted and record it in the boundary model.
   task automatic cap_accept(input logic [15:0] v);
      cap_valid   = 1'b1;
      cap_v       = v;
      cap_v_alpha = v + 16'd1;
      cap_f       = v + 16'd2;
      mv[mcap]    = v;
      mva[mcap]   = v + 16'd1;
      mf[mcap]    = v + 16'd2;
      mcap++;
   endtask

   task automatic begin_pass(input logic fp, input logic [10:0] len);
      start      = 1'b1;
      first_pass = fp;
      t_len      = len;
      tick();
      start = 1'b0;
      mcap  = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      first_pass  = 1'b0;
      t_len       = '0;
      minusAlpha  = MA;
      t_valid     = 1'b0;
      t_data      = '0;
      cap_valid   = 1'b0;
      cap_v       = '0;
      cap_v_alpha = '0;
      cap_f       = '0;
      mcap        = 0;
      #2 rst = 1'b0;
      #1;
      check("rst_ready",  t_ready,    1'b0);
      check("rst_enable", pe_enable,  1'b0);
      check("rst_lock",   pe_lock,    1'b0);
      check("rst_nl",     newLine,    1'b0);
      check("rst_done",   done,       1'b0);
      check("rst_t",      tOut,       2'd0);
      check("rst_v",      vOut,       16'd0);
      check("rst_va",     vOut_alpha, 16'd0);
      check("rst_f",      fOut,       16'd0);
      tick();
      tick();
      @(negedge clk) rst = 1'b1;
      tick();

      // First pass, four characters back to back.
      begin_pass(1'b1, 11'd4);
      check("a_ready",  t_ready,   1'b1);
      check("a_enable", pe_enable, 1'b1);
      for (int i = 0; i < 4; i++) begin
         send(i[1:0], (i == 0), 16'd0, MA, MA);
         tick();
         check_fire("a_char");
      end
      t_valid = 1'b0;
      check("a_drain_ready", t_ready, 1'b0);
      tick();
      check("a_pad_t",  tOut,       2'd0);
      check("a_pad_va", vOut_alpha, 16'd0);
      check("a_pad_lk", pe_lock,    1'b0);
      for (int i = 0; i < 4; i++) begin
         cap_accept(16'd100 + 16'(i * 10));
         tick();
         check("a_done", done, (i == 3));
      end
      cap_valid = 1'b0;
      tick();
      check("a_done_end", done,      1'b0);
      check("a_enable_0", pe_enable, 1'b0);

      // Stall after the first character; a capture under lock must be ignored.
      begin_pass(1'b1, 11'd3);
      send(2'd1, 1'b1, 16'd0, MA, MA);
      tick();
      check_fire("b_c0");
      t_valid = 1'b0;
      tick();
      check("b_stall1_lk", pe_lock, 1'b1);
      check("b_stall1_t",  tOut,    2'd1);
      cap_valid = 1'b1;
      cap_v     = 16'd999;
      tick();
      check("b_stall2_lk", pe_lock, 1'b1);
      check("b_stall2_t",  tOut,    2'd1);
      cap_valid = 1'b0;
      send(2'd2, 1'b0, 16'd0, MA, MA);
      tick();
      check_fire("b_c1");
      send(2'd3, 1'b0, 16'd0, MA, MA);
      tick();
      check_fire("b_c2");
      t_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cap_accept(16'(10 * (i + 1)));
         tick();
         check("b_done", done, (i == 2));
      end
      cap_valid = 1'b0;
      tick();

      // Replay pass with overlapping capture at a different index.
      begin_pass(1'b0, 11'd3);
      send(2'd0, 1'b1, mv[0], mva[0], mf[0]);
      tick();
      check_fire("c_c0");
      send(2'd1, 1'b0, mv[1], mva[1], mf[1]);
      cap_accept(16'd40);
      tick();
      check_fire("c_c1");
      send(2'd2, 1'b0, mv[2], mva[2], mf[2]);
      cap_accept(16'd50);
      tick();
      check_fire("c_c2");
      t_valid = 1'b0;
      cap_accept(16'd60);
      tick();
      check("c_done", done, 1'b1);
      cap_valid = 1'b0;
      tick();
      check("c_done_end", done,      1'b0);
      check("c_enable_0", pe_enable, 1'b0);

      // Replay of the column captured during the previous pass.
      begin_pass(1'b0, 11'd3);
      for (int i = 0; i < 3; i++) begin
         send(i[1:0], (i == 0), mv[i], mva[i], mf[i]);
         tick();
         check_fire("d_char");
      end
      t_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cap_accept(16'd70 + 16'(i));
         tick();
         check("d_done", done, (i == 2));
      end
      cap_valid = 1'b0;
      tick();

      // Captures arrive five cycles after each send.
      begin_pass(1'b1, 11'd2);
      send(2'd3, 1'b1, 16'd0, MA, MA);
      tick();
      check_fire("e_c0");
      send(2'd2, 1'b0, 16'd0, MA, MA);
      tick();
      check_fire("e_c1");
      t_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("e_wait_done", done, 1'b0);
      end
      cap_accept(16'd1);
      tick();
      check("e_cap1_done", done, 1'b0);
      cap_accept(16'd2);
      tick();
      check("e_cap2_done", done,      1'b1);
      check("e_cap2_en",   pe_enable, 1'b1);
      cap_valid = 1'b0;
      tick();
      check("e_end_done", done,      1'b0);
      check("e_end_en",   pe_enable, 1'b0);

      // Zero-length pass.
      begin_pass(1'b1, 11'd0);
      check("f_done",   done,    1'b1);
      check("f_ready",  t_ready, 1'b0);
      tick();
      check("f_done_0", done,      1'b0);
      check("f_ready2", t_ready,   1'b0);
      check("f_en_0",   pe_enable, 1'b0);

      // Reset in the middle of a pass, then a normal pass.
      begin_pass(1'b1, 11'd4);
      send(2'd2, 1'b1, 16'd0, MA, MA);
      tick();
      check_fire("g_c0");
      send(2'd1, 1'b0, 16'd0, MA, MA);
      tick();
      check_fire("g_c1");
      t_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("g_rst_t",     tOut,       2'd0);
      check("g_rst_nl",    newLine,    1'b0);
      check("g_rst_va",    vOut_alpha, 16'd0);
      check("g_rst_f",     fOut,       16'd0);
      check("g_rst_en",    pe_enable,  1'b0);
      check("g_rst_ready", t_ready,    1'b0);
      check("g_rst_lock",  pe_lock,    1'b0);
      check("g_rst_done",  done,       1'b0);
      @(negedge clk) rst = 1'b1;
      tick();
      check("g_idle_en", pe_enable, 1'b0);
      begin_pass(1'b1, 11'd1);
      check("g_ready", t_ready, 1'b1);
      send(2'd3, 1'b1, 16'd0, MA, MA);
      tick();
      check_fire("g_c2");
      t_valid = 1'b0;
      cap_accept(16'd5);
      tick();
      check("g_done", done, 1'b1);
      cap_valid = 1'b0;
      tick();
      check("g_end_en", pe_enable, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pass_feeder.md
# pass_feeder

Upstream boundary stage for the systolic Smith-Waterman PE array. It streams the target sequence into the first PE and generates the pass-start marker and enable/lock controls. It also supplies the left-boundary column: zeros on the first pass, and on later passes the column captured from the last PE of the previous pass. It also captures the last PE's outputs so a query longer than the array can be processed in multiple passes.

## Interface
- VEF_BIT, 16: width of V/E/F scores, two's complement signed; equals the shared score width.
- T_MAX_LEN, 1024: maximum target length; depth of the boundary buffer.
- ADDR_BIT, 10: log2(T_MAX_LEN).
- Reset is rst, asynchronous, active-low; the clock is clk.
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a pass; sampled only in IDLE.
- first_pass  in  1  sampled with start; 1 = zero boundary, 0 = replay buffer.
- t_len  in  ADDR_BIT+1  target length for this pass, sampled with start.
- minusAlpha  in  VEF_BIT  gap-open penalty (negative value).
- t_valid  in  1  target character valid.
- t_data  in  2  target character.
- t_ready  out  1  feeder accepts t_data this cycle.
- pe_enable  out  1  to PE enable; low clears the array.
- pe_lock  out  1  to PE lock; high freezes the array.
- newLine  out  1  to PE newLineIn; high with the first character of a pass.
- tOut  out  2  to PE tIn.
- vOut, vOut_alpha, fOut  out  VEF_BIT each  to PE vIn, vIn_alpha, fIn.
- cap_valid  in  1  last PE output is a real cell; generated by the array's valid shift chain.
- cap_v, cap_v_alpha, cap_f  in  VEF_BIT each  last PE vOut, vOut_alpha, fOut.
- done  out  1  one-cycle pulse when the pass has been fully captured.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start with t_len>0 → RUN; clear send_cnt and cap_cnt.
  - start with t_len==0 → DONE.
- RUN:
  - t_ready = 1.
  - fire = t_valid & t_ready.
  - On fire, register the outputs:
    - tOut = t_data.
    - newLine = (send_cnt==0).
    - Boundary on a first pass: vOut = 0, vOut_alpha = minusAlpha, fOut = minusAlpha.
    - Boundary on a later pass: buffer[send_cnt] fields.
    - send_cnt += 1.
  - When fire occurs with send_cnt == t_len-1 → DRAIN.
- DRAIN:
  - t_ready = 0; pe_lock = 0.
  - tOut = 0, newLine = 0, boundary outputs = 0 (padding cells; never captured).
  - When cap_cnt reaches t_len → DONE.
- DONE: done = 1 for one cycle → IDLE.
- pe_lock:
  - Registered: pe_lock <= ~fire while in RUN.
  - When fire is absent, the outputs hold their values and the array freezes.
- pe_enable: 1 in RUN, DRAIN and DONE; 0 in IDLE.
- Capture:
  - When cap_valid & ~pe_lock in RUN or DRAIN, write {cap_v, cap_v_alpha, cap_f} to buffer[cap_cnt], then cap_cnt += 1.
  - cap_valid is ignored in IDLE/DONE and once cap_cnt == t_len.
- In-place reuse: the write to index i always occurs at least one array latency after the read of index i in the same pass, so the same buffer serves both read and write.
- Arithmetic: no computation beyond counters; scores pass through unmodified.
- start while busy: ignored.
- t_len > T_MAX_LEN: behaviour is undefined; the driver guarantees this never happens.

## Timing
- Reset values:
  - state = IDLE.
  - t_ready = 0, pe_enable = 0, pe_lock = 0, newLine = 0, done = 0.
  - tOut = 0, vOut = 0, vOut_alpha = 0, fOut = 0.
  - send_cnt = 0, cap_cnt = 0.
- The buffer is not reset.
- Latency: t_data accepted at edge k appears on tOut after edge k, with pe_lock=0 in the same cycle.
- First character: t_ready rises the cycle after start.
- Stall: t_valid low during RUN gives pe_lock=1 in the next cycle; outputs stay frozen until the next fire.
- Reset mid-pass: everything returns to reset values immediately and pe_enable drops, clearing the array. Buffer contents are then invalid; the next pass must use first_pass=1.
- Capture and read on the same cycle at different indices: both happen.

## Structure
- Shared package / include: VEF_BIT (same definition as the PE score width), state encoding localparams.
- One sub-module, boundary_buf: register array, VEF_BIT*3 wide, T_MAX_LEN deep, with asynchronous read and synchronous write. The FSM and counters stay in pass_feeder.

## Test plan
- First pass, t_len=4, t_valid always high, characters 0,1,2,3:
  - tOut = 0,1,2,3 on consecutive cycles; newLine only on the first.
  - vOut = 0, vOut_alpha = fOut = minusAlpha (-2).
- Stall: t_len=3, t_valid low for 2 cycles after the first character → pe_lock high exactly 2 cycles; tOut is held at the first character.
- Second pass: preload capture values v = 10,20,30 with first_pass=0, t_len=3 → vOut = 10,20,30 in order, alongside the matching v_alpha and f values.
- Drain and done: t_len=2, cap_valid asserted 5 cycles after each send → done pulses one cycle after the second capture; pe_enable drops the following cycle.
- t_len=0 start → done the next cycle; t_ready never rises.
- Reset asserted mid-RUN → all outputs are 0 and state is IDLE; after release, start is accepted normally.
